// File: rtl/tdm_demux4.sv
// Receive-side 4:1 TDM demultiplexer: locks to frame_sync, fills shadow slots,
// and commits complete frames to a..d. Optional resync checking: SYNC_CHECK_EN.
module tdm_demux4 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             frame_valid,
  output logic             s1,
  output logic             s0,
  output logic             locked,
  output logic             sync_err
);

  // Input handshake: din/frame_sync are sampled only on cycles where
  // din_valid is high (a beat); there is no back-pressure, every beat is taken.

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [WIDTH-1:0] sh_c_q, sh_c_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             frame_valid_q, frame_valid_d;
  logic             sync_err_q, sync_err_d;
  logic             resync;

  // A sync beat away from slot 0 restarts the frame instead of filling a slot.
  always_comb begin
`ifdef SYNC_CHECK_EN
    resync = frame_sync && (slot_q != 2'd0);
`else
    resync = 1'b0;
`endif
  end

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    sh_a_d        = sh_a_q;
    sh_b_d        = sh_b_q;
    sh_c_d        = sh_c_q;
    a_d           = a_q;
    b_d           = b_q;
    c_d           = c_q;
    d_d           = d_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;

    case (state_q)
      HUNT: begin
        if (din_valid && frame_sync) begin
          sh_a_d  = din;
          slot_d  = 2'd1;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (din_valid) begin
          if (resync) begin
            sync_err_d = 1'b1;
            sh_a_d     = din;
            slot_d     = 2'd1;
          end else begin
            case (slot_q)
              2'd0: sh_a_d = din;
              2'd1: sh_b_d = din;
              2'd2: sh_c_d = din;
              default: begin
                // Slot 3 completes the frame; its word goes straight to d.
                a_d           = sh_a_q;
                b_d           = sh_b_q;
                c_d           = sh_c_q;
                d_d           = din;
                frame_valid_d = 1'b1;
              end
            endcase
            slot_d = slot_q + 2'd1;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HUNT;
      slot_q        <= 2'd0;
      sh_a_q        <= '0;
      sh_b_q        <= '0;
      sh_c_q        <= '0;
      a_q           <= '0;
      b_q           <= '0;
      c_q           <= '0;
      d_q           <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      sh_a_q        <= sh_a_d;
      sh_b_q        <= sh_b_d;
      sh_c_q        <= sh_c_d;
      a_q           <= a_d;
      b_q           <= b_d;
      c_q           <= c_d;
      d_q           <= d_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign a           = a_q;
  assign b           = b_q;
  assign c           = c_q;
  assign d           = d_q;
  assign frame_valid = frame_valid_q;
  assign s1          = slot_q[1];
  assign s0          = slot_q[0];
  assign locked      = (state_q == LOCKED);
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4 (WIDTH=1): vector table for reset/hunt/back-to-back/gap,
// hand sequences for resync and mid-frame reset, scoreboard on frame_valid.
module tb_tdm_demux4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic din_valid = 1'b0;
  logic frame_sync = 1'b0;
  logic a, b, c, d;
  logic frame_valid, s1, s0, locked, sync_err;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  tdm_demux4 #(.WIDTH(1)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .frame_sync(frame_sync), .a(a), .b(b), .c(c), .d(d),
    .frame_valid(frame_valid), .s1(s1), .s0(s0), .locked(locked),
    .sync_err(sync_err)
  );

  typedef struct packed {
    logic       rst;
    logic       v;
    logic       sync;
    logic       din;
    logic [3:0] abcd;
    logic       fv;
    logic [1:0] slot;
    logic       lk;
  } vec_t;

  vec_t vec[26];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive one cycle of inputs at negedge, then sample #1 after the consuming edge.
  task automatic step(input logic r, input logic v, input logic s, input logic dv);
    @(negedge clk);
    rst = r; din_valid = v; frame_sync = s; din = dv;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic v, input logic s, input logic dv,
                              input logic [3:0] abcd, input logic fv,
                              input logic [1:0] slot, input logic lk);
    vec_t t;
    t.rst = r; t.v = v; t.sync = s; t.din = dv;
    t.abcd = abcd; t.fv = fv; t.slot = slot; t.lk = lk;
    return t;
  endfunction

  // Scoreboard: every frame_valid pulse must match the oldest expected frame.
  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_commit", {4'd0, a, b, c, d}, 8'hff);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        chk("sb_frame", {4'd0, a, b, c, d}, {4'd0, e});
      end
    end
  end

  initial begin
    // reset with din_valid toggling
    vec[0]  = mk(1, 1, 1, 1, 4'b0000, 0, 2'b00, 0);
    vec[1]  = mk(1, 0, 0, 0, 4'b0000, 0, 2'b00, 0);
    // hunt: unsynced beats discarded, then sync frame 1,0,1,1
    vec[2]  = mk(0, 1, 0, 1, 4'b0000, 0, 2'b00, 0);
    vec[3]  = mk(0, 1, 0, 0, 4'b0000, 0, 2'b00, 0);
    vec[4]  = mk(0, 1, 0, 1, 4'b0000, 0, 2'b00, 0);
    vec[5]  = mk(0, 1, 1, 1, 4'b0000, 0, 2'b01, 1);
    vec[6]  = mk(0, 1, 0, 0, 4'b0000, 0, 2'b10, 1);
    vec[7]  = mk(0, 1, 0, 1, 4'b0000, 0, 2'b11, 1);
    vec[8]  = mk(0, 1, 0, 1, 4'b1011, 1, 2'b00, 1);
    vec[9]  = mk(0, 0, 0, 0, 4'b1011, 0, 2'b00, 1);
    // back-to-back frames 1100 then 0110 (second slot 0 without sync)
    vec[10] = mk(0, 1, 1, 1, 4'b1011, 0, 2'b01, 1);
    vec[11] = mk(0, 1, 0, 1, 4'b1011, 0, 2'b10, 1);
    vec[12] = mk(0, 1, 0, 0, 4'b1011, 0, 2'b11, 1);
    vec[13] = mk(0, 1, 0, 0, 4'b1100, 1, 2'b00, 1);
    vec[14] = mk(0, 1, 0, 0, 4'b1100, 0, 2'b01, 1);
    vec[15] = mk(0, 1, 0, 1, 4'b1100, 0, 2'b10, 1);
    vec[16] = mk(0, 1, 0, 1, 4'b1100, 0, 2'b11, 1);
    vec[17] = mk(0, 1, 0, 0, 4'b0110, 1, 2'b00, 1);
    // gap of 3 idle cycles after slot 1 (unqualified sync/din ignored)
    vec[18] = mk(0, 1, 0, 1, 4'b0110, 0, 2'b01, 1);
    vec[19] = mk(0, 1, 0, 0, 4'b0110, 0, 2'b10, 1);
    vec[20] = mk(0, 0, 1, 1, 4'b0110, 0, 2'b10, 1);
    vec[21] = mk(0, 0, 0, 0, 4'b0110, 0, 2'b10, 1);
    vec[22] = mk(0, 0, 1, 1, 4'b0110, 0, 2'b10, 1);
    vec[23] = mk(0, 1, 0, 0, 4'b0110, 0, 2'b11, 1);
    vec[24] = mk(0, 1, 0, 1, 4'b1001, 1, 2'b00, 1);
    vec[25] = mk(0, 0, 0, 0, 4'b1001, 0, 2'b00, 1);

    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      rst = vec[i].rst; din_valid = vec[i].v; frame_sync = vec[i].sync; din = vec[i].din;
      if (vec[i].fv) exp_q.push_back(vec[i].abcd);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_abcd", i), {4'd0, a, b, c, d}, {4'd0, vec[i].abcd});
      chk($sformatf("vec%0d_fv", i), {7'd0, frame_valid}, {7'd0, vec[i].fv});
      chk($sformatf("vec%0d_slot", i), {6'd0, s1, s0}, {6'd0, vec[i].slot});
      chk($sformatf("vec%0d_locked", i), {7'd0, locked}, {7'd0, vec[i].lk});
      chk($sformatf("vec%0d_err", i), {7'd0, sync_err}, 8'd0);
    end

    // Resync: sync beat arrives at slot 2 mid-frame.
    step(0, 1, 1, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 1);
`ifdef SYNC_CHECK_EN
    chk("resync_err_pulse", {7'd0, sync_err}, 8'd1);
    chk("resync_slot", {6'd0, s1, s0}, 8'd1);
    chk("resync_no_fv", {7'd0, frame_valid}, 8'd0);
    step(0, 1, 0, 1);
    chk("resync_err_once", {7'd0, sync_err}, 8'd0);
    chk("resync_slot2", {6'd0, s1, s0}, 8'd2);
    step(0, 1, 0, 1);
    chk("resync_no_fv2", {7'd0, frame_valid}, 8'd0);
    exp_q.push_back(4'b1111);
    step(0, 1, 0, 1);
    chk("resync_fv", {7'd0, frame_valid}, 8'd1);
    chk("resync_abcd", {4'd0, a, b, c, d}, 8'b0000_1111);
`else
    chk("count_err_zero", {7'd0, sync_err}, 8'd0);
    chk("count_slot", {6'd0, s1, s0}, 8'd3);
    exp_q.push_back(4'b0011);
    step(0, 1, 0, 1);
    chk("count_fv", {7'd0, frame_valid}, 8'd1);
    chk("count_abcd", {4'd0, a, b, c, d}, 8'b0000_0011);
    chk("count_err_zero2", {7'd0, sync_err}, 8'd0);
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    chk("count_err_zero3", {7'd0, sync_err}, 8'd0);
`endif

    // Reset mid-frame after 2 beats.
    step(1, 0, 0, 0);
    chk("pre_rst_locked", {7'd0, locked}, 8'd0);
    step(0, 1, 1, 1);
    chk("mid_locked", {7'd0, locked}, 8'd1);
    step(0, 1, 0, 1);
    chk("mid_slot", {6'd0, s1, s0}, 8'd2);
    step(1, 1, 0, 1);
    chk("mid_rst_fv", {7'd0, frame_valid}, 8'd0);
    chk("mid_rst_locked", {7'd0, locked}, 8'd0);
    chk("mid_rst_abcd", {4'd0, a, b, c, d}, 8'd0);
    chk("mid_rst_slot", {6'd0, s1, s0}, 8'd0);
    step(0, 1, 0, 1);
    chk("rehunt_discard", {7'd0, locked}, 8'd0);
    step(0, 1, 1, 0);
    step(0, 1, 0, 1);
    step(0, 1, 0, 0);
    exp_q.push_back(4'b0101);
    step(0, 1, 0, 1);
    chk("rehunt_fv", {7'd0, frame_valid}, 8'd1);
    chk("rehunt_abcd", {4'd0, a, b, c, d}, 8'b0000_0101);
    chk("rehunt_locked", {7'd0, locked}, 8'd1);
    step(0, 0, 0, 0);
    chk("rehunt_fv_pulse", {7'd0, frame_valid}, 8'd0);
    step(0, 0, 0, 0);

    chk("sb_drained", exp_q.size() == 0 ? 8'd0 : 8'd1, 8'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
